unpacker_n_to_kbit: RTL

Width-reducing data unpacker: accepts one wide word of FACTOR×OUT_WIDTH bits and serializes it into FACTOR narrow words of OUT_WIDTH bits each. It is the inverse of the team's K-to-N data packer and emits the most-significant slice first, so the packer's output fed here reproduces the original narrow stream in order. It sits on the receive side of a width-conversion path, between a wide datapath and a narrow consumer. Both sides use valid/ready handshakes.

---
 rtl/unpacker_n_to_kbit.sv | 107 ++++++++++
 1 files changed

// File: rtl/unpacker_n_to_kbit.sv
// unpacker_n_to_kbit: splits one FACTOR*OUT_WIDTH wide word into FACTOR
// narrow OUT_WIDTH slices, most-significant slice first.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   clr               synchronous abort, drops the word in progress
//   in_valid/in_ready wide-side handshake, data_in carries the word
//   out_valid/out_ready narrow-side handshake, data_out carries a slice
//   out_last          current slice is the final slice of its word
//   out_idx           index of the current slice, 0..FACTOR-1
module unpacker_n_to_kbit #(
    parameter int FACTOR    = 3,
    parameter int OUT_WIDTH = 8,
    localparam int CNT_W    = $clog2(FACTOR)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FACTOR*OUT_WIDTH-1:0] data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        data_out,
    output logic                        out_last,
    output logic [CNT_W-1:0]            out_idx
);

    localparam int W = FACTOR * OUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FACTOR - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [W-1:0]     sreg;
    logic [W-1:0]     sreg_n;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_n;
    logic             is_last;
    logic             in_xfer;
    logic             out_xfer;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        is_last   = (idx == LAST);
        out_valid = (state == SHIFT);
        // A new word is only taken when idle or when the last slice
        // leaves this cycle; that keeps consecutive words bubble-free.
        in_ready  = ~clr & ((state == IDLE) | (is_last & out_ready));
        data_out  = out_valid ? sreg[W-1 -: OUT_WIDTH] : '0;
        out_idx   = out_valid ? idx : '0;
        out_last  = out_valid & is_last;
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;

        state_n = state;
        sreg_n  = sreg;
        idx_n   = idx;

        if (clr) begin
            state_n = IDLE;
            sreg_n  = '0;
            idx_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_xfer) begin
                        state_n = SHIFT;
                        sreg_n  = data_in;
                        idx_n   = '0;
                    end
                end
                SHIFT: begin
                    if (out_xfer) begin
                        if (!is_last) begin
                            sreg_n = sreg << OUT_WIDTH;
                            idx_n  = idx + 1'b1;
                        end else if (in_xfer) begin
                            sreg_n = data_in;
                            idx_n  = '0;
                        end else begin
                            state_n = IDLE;
                            sreg_n  = '0;
                            idx_n   = '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
